mmio_fabric: RTL and testbench
==============================

# mmio_fabric

Parametrised memory-mapped interconnect between the core's single data port and N peripheral/memory slaves. It replaces point-to-point wiring of the core data port to the memory block with address decode, per-slave request routing and registered response return. It also adds unmapped-address and timeout error detection. It sits in the CPU top between core and memory, keyboard and video slaves, and holds one outstanding transaction at a time.

## Interface
- N_SLV, 4, number of slave channels (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SLV_BASE, {N_SLV{ADDR_W'0}}, packed per-slave base addresses
- SLV_MASK, {N_SLV{ADDR_W'0}}, packed per-slave decode masks; slave k hits when (addr & MASK[k]) == BASE[k]
- TIMEOUT, 255, cycles to wait for a slave response before erroring (1..65535)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error

- CLK_CPU  in  1  clock
- resetn  in  1  asynchronous active-low reset
- mst_en  in  1  request strobe from core
- mst_write  in  1  1 = store, 0 = load
- mst_size  in  2  store_size encoding (00 byte, 01 half, 10 word)
- mst_addr  in  ADDR_W  request address
- mst_wdata  in  DATA_W  store data
- mst_ready  out  1  fabric idle, request accepted this cycle if mst_en
- mst_write_ready  out  1  one-cycle store-complete pulse
- mst_rdata  out  DATA_W  load data, valid with mst_rdata_valid
- mst_rdata_valid  out  1  one-cycle load-complete pulse
- mst_err  out  1  one-cycle pulse alongside completion on unmapped/timeout
- slv_en  out  N_SLV  one-hot one-cycle request strobe
- slv_write, slv_size, slv_addr, slv_wdata  out  1/2/ADDR_W/DATA_W  shared registered request fields; slv_addr = mst_addr & ~MASK[k]
- slv_write_ready  in  N_SLV  per-slave store-complete
- slv_rdata  in  N_SLV*DATA_W  packed per-slave load data
- slv_rdata_valid  in  N_SLV  per-slave load-complete
- err_addr  out  ADDR_W  address of most recent errored transaction (debug mux)
- err_count  out  16  saturating error counter

## Operation
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE: mst_ready=1. mst_en=1 latches write/size/addr/wdata and goes to ISSUE.
- Decode is combinational on the latched address. The lowest matching index wins when windows overlap. No match sets the error flag.
- ISSUE: on a hit, slv_en[k]=1 for exactly this cycle, the timeout counter loads TIMEOUT, and the FSM goes to WAIT. On no match, no slv_en is driven and the FSM goes to RESP with the error flag set.
- WAIT: only the selected slave's slv_write_ready (store) or slv_rdata_valid (load) is honoured. Wrong-type and non-selected responses are ignored. On a response, its rdata is captured and the FSM goes to RESP. The counter decrements each cycle. At 0 with no response, the error flag is set and the FSM goes to RESP. A response arriving in the same cycle the counter hits 0 wins (no error).
- RESP: pulse mst_write_ready or mst_rdata_valid per the latched write bit. mst_rdata = captured data, or ERR_DATA on an errored load. On error, pulse mst_err, update err_addr and increment err_count (saturates at 16'hFFFF). Return to IDLE.
- A late slave response after a timeout is discarded.
- mst_en while not IDLE is ignored.

## Timing
- Reset values: all outputs 0 except mst_ready=1 and mst_rdata=0. The FSM resets to IDLE and the counter to 0.
- Reset mid-transaction aborts it. No completion pulse is emitted.
- Mapped latency, from the accept edge (mst_en sampled in IDLE) to the completion pulse, is 3 + L cycles, where L is slave response latency in cycles after slv_en (L≥0 for a same-cycle combinational response).
- Unmapped access completes 2 cycles after accept.
- Timeout completes TIMEOUT+3 cycles after accept.
- Back-to-back: a new request can be accepted the cycle after RESP.

## Structure
- Package mmio_pkg holds the fabric state enum, size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD) and the default ERR_DATA. This package is shared with the memory block.
- One sub-module, mmio_decode: combinational N_SLV-way mask/base decoder producing a one-hot hit vector, a hit index and a miss flag, with priority encoding.

## Test plan
- N_SLV=2, BASE0=0x0000_0000/MASK0=0xFFFF_0000, BASE1=0x0001_0000/MASK1=0xFFFF_0000. Load from 0x0001_0004, slave1 returns 0x1234_5678 with L=2 -> slv_en=2'b10, slv_addr=0x0004, mst_rdata_valid pulse 5 cycles after accept, mst_rdata=0x1234_5678, mst_err=0.
- Store byte (mst_size=00) to 0x0000_0010 with wdata 0xAB, L=0 -> slv_en[0] pulse, slv_size=00, slv_wdata=0xAB, mst_write_ready 3 cycles after accept.
- Load from 0x0005_0000 (unmapped) -> no slv_en, mst_rdata=0xDEAD_BEEF and mst_err pulse 2 cycles after accept, err_addr=0x0005_0000, err_count=1.
- TIMEOUT=4, slave never responds -> mst_err plus a completion pulse 7 cycles after accept. A response from that slave in the following cycle is ignored, with no extra pulse.
- Overlap (BASE1 equal to BASE0) -> slave0 selected. Slave1 asserting rdata_valid during WAIT has no effect.
- resetn low during WAIT -> all outputs at reset values immediately. After release, a fresh load completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO fabric and the memory block.
//   fab_state_e      - fabric transaction FSM states
//   SZ_BYTE/HALF/WORD - store size encoding carried on mst_size/slv_size
//   ERR_DATA_DEFAULT - read data returned on an errored load
//   idx_width()      - width of a slave index for a given slave count
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fab_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // A single slave still needs a 1-bit index to keep port widths legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_decode.sv
// mmio_decode: combinational N_SLV-way mask/base address decoder.
//   addr_i - address to decode
//   hit_o  - one-hot hit vector (at most one bit set)
//   idx_o  - index of the selected slave (0 on miss)
//   miss_o - no slave window matches
// Slave k matches when (addr & MASK[k]) == BASE[k]; lowest index wins on overlap.
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int unsigned                    N_SLV    = 4,
    parameter int unsigned                    ADDR_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0]        SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0]        SLV_MASK = '0,
    parameter int unsigned                    IDX_W    = idx_width(N_SLV)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [N_SLV-1:0]  hit_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              miss_o
);

    always_comb begin
        hit_o  = '0;
        idx_o  = '0;
        miss_o = 1'b1;
        // Ascending scan; once a hit is recorded later matches are skipped.
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (miss_o &&
                ((addr_i & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W])) begin
                hit_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
                miss_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmio_fabric.sv
// mmio_fabric: single-outstanding memory-mapped interconnect from the core
// data port to N_SLV slaves, with unmapped-address and timeout errors.
//   CLK_CPU, resetn                     - clock, async active-low reset
//   mst_en/write/size/addr/wdata        - core request
//   mst_ready                           - fabric idle / request accepted
//   mst_write_ready, mst_rdata(_valid)  - one-cycle completion pulses
//   mst_err                             - error flag alongside completion
//   slv_en                              - one-hot one-cycle slave strobe
//   slv_write/size/addr/wdata           - shared registered request fields
//   slv_write_ready, slv_rdata(_valid)  - per-slave responses
//   err_addr, err_count                 - last errored address, saturating count
module mmio_fabric
    import mmio_pkg::*;
#(
    parameter int unsigned             N_SLV    = 4,
    parameter int unsigned             ADDR_W   = 32,
    parameter int unsigned             DATA_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0,
    parameter int unsigned             TIMEOUT  = 255,
    parameter logic [DATA_W-1:0]       ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                    CLK_CPU,
    input  logic                    resetn,
    input  logic                    mst_en,
    input  logic                    mst_write,
    input  logic [1:0]              mst_size,
    input  logic [ADDR_W-1:0]       mst_addr,
    input  logic [DATA_W-1:0]       mst_wdata,
    output logic                    mst_ready,
    output logic                    mst_write_ready,
    output logic [DATA_W-1:0]       mst_rdata,
    output logic                    mst_rdata_valid,
    output logic                    mst_err,
    output logic [N_SLV-1:0]        slv_en,
    output logic                    slv_write,
    output logic [1:0]              slv_size,
    output logic [ADDR_W-1:0]       slv_addr,
    output logic [DATA_W-1:0]       slv_wdata,
    input  logic [N_SLV-1:0]        slv_write_ready,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata,
    input  logic [N_SLV-1:0]        slv_rdata_valid,
    output logic [ADDR_W-1:0]       err_addr,
    output logic [15:0]             err_count
);

    localparam int unsigned IDX_W = idx_width(N_SLV);

    fab_state_e          state_q;
    logic                write_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [N_SLV-1:0]    sel_q;
    logic                err_q;
    logic [15:0]         cnt_q;
    logic [DATA_W-1:0]   cap_q;
    logic [N_SLV-1:0]    slv_en_q;
    logic [ADDR_W-1:0]   slv_addr_q;
    logic                ready_q;
    logic                wr_rdy_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_pulse_q;
    logic [ADDR_W-1:0]   err_addr_q;
    logic [15:0]         err_count_q;

    logic [N_SLV-1:0]    dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                dec_miss;
    logic [ADDR_W-1:0]   mask_sel_d;
    logic                resp_hit_d;
    logic [DATA_W-1:0]   resp_data_d;

    mmio_decode #(
        .N_SLV    (N_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .IDX_W    (IDX_W)
    ) u_decode (
        .addr_i (addr_q),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx),
        .miss_o (dec_miss)
    );

    // Only the latched slave's response of the latched type counts.
    always_comb begin
        mask_sel_d  = '0;
        resp_hit_d  = 1'b0;
        resp_data_d = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (dec_idx == IDX_W'(k)) begin
                mask_sel_d = SLV_MASK[k*ADDR_W +: ADDR_W];
            end
            if (sel_q[k]) begin
                resp_hit_d  = write_q ? slv_write_ready[k] : slv_rdata_valid[k];
                resp_data_d = slv_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            cap_q       <= '0;
            slv_en_q    <= '0;
            slv_addr_q  <= '0;
            ready_q     <= 1'b1;
            wr_rdy_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_pulse_q <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            slv_en_q    <= '0;
            wr_rdy_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mst_en) begin
                        write_q <= mst_write;
                        size_q  <= mst_size;
                        addr_q  <= mst_addr;
                        wdata_q <= mst_wdata;
                        err_q   <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (dec_miss) begin
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        slv_en_q   <= dec_hit;
                        sel_q      <= dec_hit;
                        slv_addr_q <= addr_q & ~mask_sel_d;
                        cnt_q      <= 16'(TIMEOUT);
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Response is checked before expiry so a last-cycle reply wins.
                    if (resp_hit_d) begin
                        cap_q   <= resp_data_d;
                        state_q <= ST_RESP;
                    end else if (cnt_q == '0) begin
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_RESP: begin
                    if (write_q) begin
                        wr_rdy_q <= 1'b1;
                    end else begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= err_q ? ERR_DATA : cap_q;
                    end
                    if (err_q) begin
                        err_pulse_q <= 1'b1;
                        err_addr_q  <= addr_q;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_q <= err_count_q + 16'd1;
                        end
                    end
                    sel_q   <= '0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mst_ready       = ready_q;
    assign mst_write_ready = wr_rdy_q;
    assign mst_rdata       = rdata_q;
    assign mst_rdata_valid = rvalid_q;
    assign mst_err         = err_pulse_q;
    assign slv_en          = slv_en_q;
    assign slv_write       = write_q;
    assign slv_size        = size_q;
    assign slv_addr        = slv_addr_q;
    assign slv_wdata       = wdata_q;
    assign err_addr        = err_addr_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_mmio_fabric.sv
// tb_mmio_fabric: scoreboard bench for mmio_fabric. Three slaves: slave0 at
// 0x0000_xxxx, slave1 at 0x0001_xxxx, slave2 duplicating slave0's window.
module tb_mmio_fabric;
    import mmio_pkg::*;

    localparam int unsigned NS = 3;

    logic        clk;
    logic        resetn;
    logic        mst_en;
    logic        mst_write;
    logic [1:0]  mst_size;
    logic [31:0] mst_addr;
    logic [31:0] mst_wdata;
    logic        mst_ready;
    logic        mst_write_ready;
    logic [31:0] mst_rdata;
    logic        mst_rdata_valid;
    logic        mst_err;
    logic [NS-1:0] slv_en;
    logic        slv_write;
    logic [1:0]  slv_size;
    logic [31:0] slv_addr;
    logic [31:0] slv_wdata;
    logic [NS-1:0] slv_write_ready;
    logic [NS*32-1:0] slv_rdata;
    logic [NS-1:0] slv_rdata_valid;
    logic [31:0] err_addr;
    logic [15:0] err_count;

    mmio_fabric #(
        .N_SLV    (NS),
        .ADDR_W   (32),
        .DATA_W   (32),
        .SLV_BASE ({32'h0000_0000, 32'h0001_0000, 32'h0000_0000}),
        .SLV_MASK ({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
        .TIMEOUT  (4),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .CLK_CPU         (clk),
        .resetn          (resetn),
        .mst_en          (mst_en),
        .mst_write       (mst_write),
        .mst_size        (mst_size),
        .mst_addr        (mst_addr),
        .mst_wdata       (mst_wdata),
        .mst_ready       (mst_ready),
        .mst_write_ready (mst_write_ready),
        .mst_rdata       (mst_rdata),
        .mst_rdata_valid (mst_rdata_valid),
        .mst_err         (mst_err),
        .slv_en          (slv_en),
        .slv_write       (slv_write),
        .slv_size        (slv_size),
        .slv_addr        (slv_addr),
        .slv_wdata       (slv_wdata),
        .slv_write_ready (slv_write_ready),
        .slv_rdata       (slv_rdata),
        .slv_rdata_valid (slv_rdata_valid),
        .err_addr        (err_addr),
        .err_count       (err_count)
    );

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
        int          due;
        logic [31:0] eaddr;
        logic [15:0] ecnt;
    } mexp_t;

    typedef struct {
        logic [NS-1:0] en;
        logic [31:0]   addr;
        logic          wr;
        logic [1:0]    sz;
        logic [31:0]   wd;
    } sexp_t;

    mexp_t mq[$];
    sexp_t sq[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Slave models
    logic [31:0]   sdata [NS];
    int            lat   [NS];
    logic [NS-1:0] mute;
    logic [NS-1:0] pend;
    int            pcnt  [NS];
    logic [NS-1:0] pwr;
    logic [NS-1:0] inj_rv;
    logic [NS-1:0] inj_wr;

    assign slv_rdata = {sdata[2], sdata[1], sdata[0]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // Responder: latency counted from the cycle slv_en is visible.
    initial begin
        slv_write_ready = '0;
        slv_rdata_valid = '0;
        pend = '0;
        pwr  = '0;
        for (int k = 0; k < NS; k++) pcnt[k] = 0;
        forever begin
            @(negedge clk);
            slv_write_ready = inj_wr;
            slv_rdata_valid = inj_rv;
            inj_wr = '0;
            inj_rv = '0;
            if (!resetn) pend = '0;
            for (int k = 0; k < NS; k++) begin
                if (resetn && slv_en[k] && !mute[k]) begin
                    pend[k] = 1'b1;
                    pcnt[k] = lat[k];
                    pwr[k]  = slv_write;
                end
                if (pend[k]) begin
                    if (pcnt[k] == 0) begin
                        if (pwr[k]) slv_write_ready[k] = 1'b1;
                        else        slv_rdata_valid[k] = 1'b1;
                        pend[k] = 1'b0;
                    end else begin
                        pcnt[k]--;
                    end
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a completion or request.
    always @(negedge clk) begin
        if (resetn) begin
            if (mst_write_ready || mst_rdata_valid) begin
                if (mq.size() == 0) begin
                    fail_evt("completion");
                end else begin
                    mexp_t e;
                    e = mq.pop_front();
                    chk("kind", {30'd0, mst_write_ready, mst_rdata_valid}, e.wr ? 32'd2 : 32'd1);
                    chk("latency", cyc, e.due);
                    chk("mst_err", {31'd0, mst_err}, {31'd0, e.err});
                    if (!e.wr) chk("mst_rdata", mst_rdata, e.rdata);
                    if (e.err) begin
                        chk("err_addr", err_addr, e.eaddr);
                        chk("err_count", {16'd0, err_count}, {16'd0, e.ecnt});
                    end
                end
            end else if (mst_err) begin
                fail_evt("mst_err");
            end
            if (slv_en != '0) begin
                if (sq.size() == 0) begin
                    fail_evt("slv_en");
                end else begin
                    sexp_t s;
                    s = sq.pop_front();
                    chk("slv_en", {29'd0, slv_en}, {29'd0, s.en});
                    chk("slv_addr", slv_addr, s.addr);
                    chk("slv_ctl", {29'd0, slv_write, slv_size}, {29'd0, s.wr, s.sz});
                    chk("slv_wdata", slv_wdata, s.wd);
                end
            end
        end
    end

    // Returns at the second negedge after the accept edge. A stray request
    // is presented while busy and must be ignored.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int total_lat, input logic [NS-1:0] en,
                         input logic [31:0] saddr, input logic err, input logic [31:0] rd,
                         input logic [15:0] ecnt, output int due);
        bit ok;
        mexp_t e;
        sexp_t s;
        ok  = 1'b0;
        due = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = mst_ready;
        end
        if (!ok) begin
            fail_evt("wait_ready");
            return;
        end
        mst_en = 1'b1; mst_write = wr; mst_size = sz; mst_addr = a; mst_wdata = wd;
        due = cyc + 1 + total_lat;
        e.wr = wr; e.err = err; e.rdata = rd; e.due = due; e.eaddr = a; e.ecnt = ecnt;
        mq.push_back(e);
        if (en != '0) begin
            s.en = en; s.addr = saddr; s.wr = wr; s.sz = sz; s.wd = wd;
            sq.push_back(s);
        end
        @(negedge clk);
        mst_write = 1'b0; mst_addr = 32'h0009_0000; mst_wdata = 32'h7777_7777;
        @(negedge clk);
        mst_en = 1'b0;
    endtask

    task automatic rst_check();
        chk("rst_ready", {31'd0, mst_ready}, 32'd1);
        chk("rst_pulses", {29'd0, mst_write_ready, mst_rdata_valid, mst_err}, 32'd0);
        chk("rst_rdata", mst_rdata, 32'd0);
        chk("rst_slv_ctl", {26'd0, slv_en, slv_write, slv_size}, 32'd0);
        chk("rst_slv_addr", slv_addr, 32'd0);
        chk("rst_slv_wdata", slv_wdata, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
    endtask

    initial begin
        int due;
        resetn = 1'b0;
        mst_en = 1'b0; mst_write = 1'b0; mst_size = '0; mst_addr = '0; mst_wdata = '0;
        mute = '0; inj_rv = '0; inj_wr = '0;
        for (int k = 0; k < NS; k++) begin
            sdata[k] = 32'h0;
            lat[k]   = 0;
        end
        repeat (3) @(negedge clk);
        rst_check();
        resetn = 1'b1;

        // Load via slave1, L=2
        sdata[1] = 32'h1234_5678; lat[1] = 2;
        issue(1'b0, SZ_WORD, 32'h0001_0004, 32'h0, 5, 3'b010, 32'h0000_0004,
              1'b0, 32'h1234_5678, 16'd0, due);

        // Byte store via slave0, L=0
        lat[0] = 0;
        issue(1'b1, SZ_BYTE, 32'h0000_0010, 32'h0000_00AB, 3, 3'b001, 32'h0000_0010,
              1'b0, 32'h0, 16'd0, due);

        // Unmapped load
        issue(1'b0, SZ_WORD, 32'h0005_0000, 32'h0, 2, 3'b000, 32'h0,
              1'b1, 32'hDEAD_BEEF, 16'd1, due);

        // Timeout on silent slave1, then a late response the next cycle
        mute[1] = 1'b1;
        issue(1'b0, SZ_WORD, 32'h0001_0100, 32'h0, 7, 3'b010, 32'h0000_0100,
              1'b1, 32'hDEAD_BEEF, 16'd2, due);
        for (int i = 0; i < 20 && cyc < due; i++) @(negedge clk);
        #1 inj_rv[1] = 1'b1;
        @(negedge clk);
        mute[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Overlap: slave0 wins over slave2; stray responses during WAIT ignored
        sdata[0] = 32'hCAFE_0001; sdata[1] = 32'h1111_1111; sdata[2] = 32'h2222_2222;
        lat[0] = 3;
        issue(1'b0, SZ_WORD, 32'h0000_0020, 32'h0, 6, 3'b001, 32'h0000_0020,
              1'b0, 32'hCAFE_0001, 16'd0, due);
        #1 begin
            inj_rv = 3'b110;
            inj_wr = 3'b001;
        end

        // Half store via slave1, L=1, top of window
        lat[1] = 1;
        issue(1'b1, SZ_HALF, 32'h0001_FFFE, 32'h0000_BEEF, 4, 3'b010, 32'h0000_FFFE,
              1'b0, 32'h0, 16'd0, due);

        // Reset while in WAIT
        mute[0] = 1'b1;
        issue(1'b0, SZ_WORD, 32'h0000_0040, 32'h5555_AAAA, 3, 3'b001, 32'h0000_0040,
              1'b0, 32'h0, 16'd0, due);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        rst_check();
        mq.delete();
        sq.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        mute[0] = 1'b0;

        // Fresh load after reset
        sdata[1] = 32'h0BAD_F00D; lat[1] = 2;
        issue(1'b0, SZ_WORD, 32'h0001_0008, 32'h0, 5, 3'b010, 32'h0000_0008,
              1'b0, 32'h0BAD_F00D, 16'd0, due);

        // Unmapped store: counter restarted from reset
        issue(1'b1, SZ_WORD, 32'h8000_0000, 32'h0000_0001, 2, 3'b000, 32'h0,
              1'b1, 32'h0, 16'd1, due);

        // Back-to-back load via slave0, L=0
        sdata[0] = 32'h0000_00C3; lat[0] = 0;
        issue(1'b0, SZ_WORD, 32'h0000_0100, 32'h0, 3, 3'b001, 32'h0000_0100,
              1'b0, 32'h0000_00C3, 16'd0, due);

        for (int i = 0; i < 40 && mq.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("mq_drained", mq.size(), 32'd0);
        chk("sq_drained", sq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
